// File: rtl/snake_kbd_ctrl_if.sv
// snake_kbd_ctrl_if: keyboard FIFO handshake between scan-code FIFO (master) and parser (slave)
interface snake_kbd_ctrl_if;
  logic       ready;
  logic       overflow;
  logic [7:0] data;
  logic       nextdata_n;
  modport master (output ready, overflow, data, input nextdata_n);
  modport slave (input ready, overflow, data, output nextdata_n);
endinterface

// File: rtl/snake_kbd_ctrl.sv
// snake_kbd_ctrl: PS/2 scan-code parser steering up to two snakes through buffered turn queues
module snake_kbd_ctrl #(
  parameter int PLAYERS     = 2,
  parameter int QUEUE_DEPTH = 2,
  parameter int NO_REVERSE  = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  snake_kbd_ctrl_if.slave      kbd,
  input  logic                 step,
  output logic [2*PLAYERS-1:0] direction,
  output logic                 run,
  output logic                 restart,
  output logic                 err
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [2*PLAYERS-1:0] DIR_INIT = (2*PLAYERS)'(4'b1011);
  typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;
  state_t state, state_n;
  logic [7:0] code;
  logic ext, brk, space_held, r_held;
  logic [1:0] q_mem [PLAYERS][QUEUE_DEPTH];
  logic [PW-1:0] rp [PLAYERS];
  logic [PW-1:0] wp [PLAYERS];
  logic [CW-1:0] cnt [PLAYERS];
  logic [1:0] ref_dir [PLAYERS];
  logic [PLAYERS-1:0] hit, push, pop;
  logic eval, make, rel, p0_hit, p1_hit, toggle, do_restart;
  logic [1:0] key_dir;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
    return v == PW'(QUEUE_DEPTH - 1) ? '0 : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state == IDLE ? (kbd.ready ? POP : IDLE) : state == POP ? WAIT : IDLE;
    kbd.nextdata_n = state != POP;
  end

  always_comb begin
    hit = '0;
    push = '0;
    pop = '0;
    eval = state == POP;
    make = eval && code != 8'hE0 && code != 8'hF0 && !brk;
    rel = eval && code != 8'hE0 && code != 8'hF0 && brk;
    p0_hit = !ext && (code == 8'h1D || code == 8'h1B || code == 8'h1C || code == 8'h23);
    p1_hit = PLAYERS > 1 && ext && (code == 8'h75 || code == 8'h72 || code == 8'h6B || code == 8'h74);
    key_dir = code == 8'h1D || code == 8'h75 ? 2'b00 :
              code == 8'h1B || code == 8'h72 ? 2'b01 :
              code == 8'h1C || code == 8'h6B ? 2'b10 : 2'b11;
    toggle = make && code == 8'h29 && !space_held;
    do_restart = make && code == 8'h2D && !r_held;
    for (int p = 0; p < PLAYERS; p++) begin
      hit[p] = make && (p == 0 ? p0_hit : p1_hit);
      // Compare against the last queued turn so chained turns are filtered as a sequence
      ref_dir[p] = cnt[p] != '0 ? q_mem[p][wp[p] == '0 ? PW'(QUEUE_DEPTH - 1) : wp[p] - 1'b1]
                                : direction[2*p +: 2];
      push[p] = hit[p] && key_dir != ref_dir[p] && !(NO_REVERSE != 0 && key_dir[1] == ref_dir[p][1])
                && cnt[p] != CW'(QUEUE_DEPTH);
      pop[p] = step && run && cnt[p] != '0;
    end
  end

  always_ff @(posedge clk)
    for (int p = 0; p < PLAYERS; p++)
      if (push[p]) q_mem[p][wp[p]] <= key_dir;

  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      code <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      space_held <= 1'b0;
      r_held <= 1'b0;
      run <= 1'b0;
      restart <= 1'b0;
      err <= 1'b0;
      direction <= DIR_INIT;
      for (int p = 0; p < PLAYERS; p++) begin
        rp[p] <= '0;
        wp[p] <= '0;
        cnt[p] <= '0;
      end
    end else begin
      restart <= do_restart;
      if (state == IDLE && kbd.ready) code <= kbd.data;
      if (eval) begin
        ext <= code == 8'hE0 ? 1'b1 : code == 8'hF0 ? ext : 1'b0;
        brk <= code == 8'hF0 ? 1'b1 : code == 8'hE0 ? brk : 1'b0;
      end
      if (make && code == 8'h29) space_held <= 1'b1;
      if (rel && code == 8'h29) space_held <= 1'b0;
      if (make && code == 8'h2D) r_held <= 1'b1;
      if (rel && code == 8'h2D) r_held <= 1'b0;
      if (toggle) run <= !run;
      for (int p = 0; p < PLAYERS; p++) begin
        if (push[p]) wp[p] <= inc(wp[p]);
        if (pop[p]) begin
          direction[2*p +: 2] <= q_mem[p][rp[p]];
          rp[p] <= inc(rp[p]);
        end
        cnt[p] <= cnt[p] + CW'(push[p]) - CW'(pop[p]);
      end
      if (do_restart) begin
        run <= 1'b0;
        err <= 1'b0;
        direction <= DIR_INIT;
        for (int p = 0; p < PLAYERS; p++) begin
          rp[p] <= '0;
          wp[p] <= '0;
          cnt[p] <= '0;
        end
      end
      // A lost byte may have been part of a prefix, so the prefix state is discarded
      if (kbd.overflow) begin
        err <= 1'b1;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
endmodule

// File: tb/tb_snake_kbd_ctrl.sv
// tb_snake_kbd_ctrl: directed byte streams checked each cycle against a queue-based model
module tb_snake_kbd_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic step = 1'b0;
  logic [3:0] direction;
  logic run, restart, err;
  int checks = 0;
  int errors = 0;
  localparam int QD = 2;

  snake_kbd_ctrl_if kbd();
  snake_kbd_ctrl #(.PLAYERS(2), .QUEUE_DEPTH(QD), .NO_REVERSE(1)) dut (
    .clk(clk), .clr(clr), .kbd(kbd), .step(step),
    .direction(direction), .run(run), .restart(restart), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  int m_phase = 0;
  logic [7:0] m_byte = 8'h00;
  bit m_ext = 0, m_brk = 0, m_sp = 0, m_rh = 0, m_run = 0, m_restart = 0, m_err = 0;
  logic [1:0] m_dir[2] = '{2'b11, 2'b10};
  logic [1:0] mq[2][$];
  logic [7:0] p_codes[2][4] = '{'{8'h1D, 8'h1B, 8'h1C, 8'h23}, '{8'h75, 8'h72, 8'h6B, 8'h74}};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] mdl, input logic [7:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ext = 0; m_brk = 0; m_sp = 0; m_rh = 0;
    m_run = 0; m_restart = 0; m_err = 0;
    m_dir[0] = 2'b11; m_dir[1] = 2'b10;
    mq[0].delete(); mq[1].delete();
  endtask

  task automatic model_edge();
    int pl;
    logic [1:0] d, r;
    bit ok, tog, rs;
    pl = -1; d = 2'b00; r = 2'b00; ok = 0; tog = 0; rs = 0;
    m_restart = 0;
    if (m_phase == 1) begin
      void'(fifo.pop_front());
      if (m_byte == 8'hE0) m_ext = 1;
      else if (m_byte == 8'hF0) m_brk = 1;
      else if (m_brk) begin
        if (m_byte == 8'h29) m_sp = 0;
        if (m_byte == 8'h2D) m_rh = 0;
        m_brk = 0; m_ext = 0;
      end else begin
        for (int p = 0; p < 2; p++)
          for (int i = 0; i < 4; i++)
            if (m_byte == p_codes[p][i] && m_ext == (p == 1)) begin pl = p; d = 2'(i); end
        tog = m_byte == 8'h29 && !m_sp;
        rs = m_byte == 8'h2D && !m_rh;
        if (m_byte == 8'h29) m_sp = 1;
        if (m_byte == 8'h2D) m_rh = 1;
        m_ext = 0;
        if (pl >= 0) begin
          r = mq[pl].size() > 0 ? mq[pl][$] : m_dir[pl];
          ok = d != r && d != (r ^ 2'b01) && mq[pl].size() < QD;
        end
      end
    end
    if (step && m_run)
      for (int p = 0; p < 2; p++)
        if (mq[p].size() > 0) m_dir[p] = mq[p].pop_front();
    if (ok) mq[pl].push_back(d);
    if (tog) m_run = !m_run;
    if (rs) begin
      m_run = 0; m_err = 0; m_restart = 1;
      m_dir[0] = 2'b11; m_dir[1] = 2'b10;
      mq[0].delete(); mq[1].delete();
    end
    if (kbd.overflow) begin m_err = 1; m_ext = 0; m_brk = 0; end
    if (m_phase == 0) begin
      if (kbd.ready) begin m_byte = kbd.data; m_phase = 1; end
    end else m_phase = m_phase == 1 ? 2 : 0;
  endtask

  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) model_reset();
    else model_edge();
  end

  initial begin
    kbd.ready = 1'b0;
    kbd.data = 8'h00;
    kbd.overflow = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      kbd.ready = fifo.size() != 0;
      kbd.data = fifo.size() != 0 ? fifo[0] : 8'h00;
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    chk("nextdata_n", {7'd0, kbd.nextdata_n}, {7'd0, m_phase != 1});
    chk("direction", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]});
    chk("run", {7'd0, run}, {7'd0, m_run});
    chk("restart", {7'd0, restart}, {7'd0, m_restart});
    chk("err", {7'd0, err}, {7'd0, m_err});
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((fifo.size() != 0 || m_phase != 0) && n < 60);
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo.push_back(b);
    wait_idle();
  endtask

  task automatic burst(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    fifo.push_back(a); fifo.push_back(b); fifo.push_back(c); fifo.push_back(d);
    wait_idle();
  endtask

  task automatic do_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit("rst_dir", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    lit("rst_run", {7'd0, run}, {7'd0, m_run}, 8'h00);
    lit("rst_err", {7'd0, err}, {7'd0, m_err}, 8'h00);
    lit("rst_nextdata_n", {7'd0, kbd.nextdata_n}, {7'd0, m_phase != 1}, 8'h01);
    clr = 1'b0;
    // space press: strobe one cycle after latch, run toggles with the pop
    fifo.push_back(8'h29);
    @(negedge clk); #1;
    lit("pop_low", {7'd0, kbd.nextdata_n}, {7'd0, m_phase != 1}, 8'h00);
    lit("run_before", {7'd0, run}, {7'd0, m_run}, 8'h00);
    @(negedge clk); #1;
    lit("pop_high", {7'd0, kbd.nextdata_n}, {7'd0, m_phase != 1}, 8'h01);
    lit("run_on", {7'd0, run}, {7'd0, m_run}, 8'h01);
    wait_idle();
    send(8'h29);
    lit("typematic_space", {7'd0, run}, {7'd0, m_run}, 8'h01);
    send(8'hF0); send(8'h29);
    // duplicate right dropped, then up taken
    send(8'h23); send(8'hF0); send(8'h23);
    do_step();
    lit("dup_right", {6'd0, direction[1:0]}, {6'd0, m_dir[0]}, 8'h03);
    send(8'h1D);
    do_step();
    lit("up_taken", {6'd0, direction[1:0]}, {6'd0, m_dir[0]}, 8'h00);
    send(8'h2D); send(8'hF0); send(8'h2D);
    send(8'h29); send(8'hF0); send(8'h29);
    lit("prep_dir", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    lit("prep_run", {7'd0, run}, {7'd0, m_run}, 8'h01);
    // reverse filter and queue full
    burst(8'h1C, 8'h1D, 8'h1C, 8'h1B);
    chk("model_q_len", 8'(mq[0].size()), 8'd2);
    chk("model_q_head", {6'd0, mq[0][0]}, 8'h00);
    chk("model_q_tail", {6'd0, mq[0][1]}, 8'h02);
    do_step();
    lit("q_pop1", {6'd0, direction[1:0]}, {6'd0, m_dir[0]}, 8'h00);
    do_step();
    lit("q_pop2", {6'd0, direction[1:0]}, {6'd0, m_dir[0]}, 8'h02);
    do_step();
    lit("q_empty_pop", {6'd0, direction[1:0]}, {6'd0, m_dir[0]}, 8'h02);
    // extended player 1 and restart pulse
    send(8'hE0); send(8'h75);
    do_step();
    lit("p1_up", {6'd0, direction[3:2]}, {6'd0, m_dir[1]}, 8'h00);
    fifo.push_back(8'h2D);
    @(negedge clk); #1;
    @(negedge clk); #1;
    lit("restart_hi", {7'd0, restart}, {7'd0, m_restart}, 8'h01);
    lit("restart_dir", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    lit("restart_run", {7'd0, run}, {7'd0, m_run}, 8'h00);
    @(negedge clk); #1;
    lit("restart_lo", {7'd0, restart}, {7'd0, m_restart}, 8'h00);
    wait_idle();
    send(8'hF0); send(8'h2D);
    // overflow and paused step
    kbd.overflow = 1'b1;
    @(negedge clk);
    kbd.overflow = 1'b0;
    lit("err_set", {7'd0, err}, {7'd0, m_err}, 8'h01);
    send(8'h1D);
    do_step();
    lit("paused_step", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    chk("model_q_kept", 8'(mq[0].size()), 8'd1);
    send(8'h29); send(8'hF0); send(8'h29);
    do_step();
    lit("resumed_step", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h08);
    lit("err_sticky", {7'd0, err}, {7'd0, m_err}, 8'h01);
    send(8'h2D);
    lit("err_cleared", {7'd0, err}, {7'd0, m_err}, 8'h00);
    send(8'hF0); send(8'h2D);
    // clr between E0 and its code discards the prefix
    send(8'hE0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    lit("clr_dir", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    burst(8'h75, 8'h29, 8'hF0, 8'h29);
    do_step();
    lit("prefix_dropped", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    // extended player-0 code and unmapped code ignored
    burst(8'hE0, 8'h1D, 8'h1A, 8'h00);
    do_step();
    lit("ignored_codes", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h0B);
    // back-to-back bytes for both players
    burst(8'h1B, 8'hE0, 8'h6B, 8'hE0);
    burst(8'h74, 8'hE0, 8'h72, 8'h1A);
    do_step();
    lit("both_down", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h05);
    // held R does not restart again
    send(8'h2D);
    send(8'h29); send(8'hF0); send(8'h29);
    send(8'h1D);
    send(8'h2D);
    do_step();
    lit("held_r", {4'd0, direction}, {4'd0, m_dir[1], m_dir[0]}, 8'h08);
    send(8'hF0); send(8'h2D);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
